// File: rtl/mmu_subword.sv
// Sub-word memory unit: byte/halfword/word loads, SW and read-modify-write SB/SH, with a busy timeout.
// Optional MMU_ALIGN_CHECK_EN rejects misaligned word/halfword ops with bus_err.
module mmu_subword #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] instr_addr,
  output logic [31:0]           instr_out,
  output logic                  instr_valid,
  input  logic [3:0]            data_opt,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  bus_err,
  output logic [ADDR_WIDTH-1:0] dev_mem_addr,
  input  logic [31:0]           dev_mem_data_in,
  output logic [31:0]           dev_mem_data_out,
  output logic                  dev_mem_is_write,
  input  logic                  dev_mem_busy
);

  localparam logic [3:0] OpLw  = 4'd1;
  localparam logic [3:0] OpLb  = 4'd2;
  localparam logic [3:0] OpLbu = 4'd3;
  localparam logic [3:0] OpLh  = 4'd4;
  localparam logic [3:0] OpLhu = 4'd5;
  localparam logic [3:0] OpSw  = 4'd6;
  localparam logic [3:0] OpSb  = 4'd7;
  localparam logic [3:0] OpSh  = 4'd8;

  // Abort fires on the busy cycle that would bring the counter up to TIMEOUT_CYCLES.
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRmwRd, StStore} state_e;

  state_e                state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [31:0]           data_out_q, data_out_d;
  logic [31:0]           wr_q, wr_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  op_none;
  logic                  misaligned;

  function automatic logic [31:0] load_lane(logic [3:0] op, logic [1:0] a, logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    unique case (op)
      OpLb:    return {{24{b[7]}}, b};
      OpLbu:   return {24'h0, b};
      OpLh:    return {{16{h[15]}}, h};
      OpLhu:   return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(logic [3:0] op, logic [1:0] a, logic [31:0] w,
                                        logic [31:0] d);
    logic [31:0] m;
    m = w;
    if (op == OpSb) begin
      m[{a, 3'b000} +: 8] = d[7:0];
    end else if (a[1]) begin
      m[31:16] = d[15:0];
    end else begin
      m[15:0] = d[15:0];
    end
    return m;
  endfunction

  assign op_none = (data_opt == 4'd0) || (data_opt > OpSh);

`ifdef MMU_ALIGN_CHECK_EN
  assign misaligned = ((data_opt == OpLh || data_opt == OpLhu || data_opt == OpSh) && data_addr[0])
                    || ((data_opt == OpLw || data_opt == OpSw) && (data_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    wr_d       = wr_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!op_none) begin
          op_d    = data_opt;
          addr_d  = data_addr;
          wdata_d = data_in;
          if (misaligned) begin
            err_d = 1'b1;
          end else if (data_opt >= OpLw && data_opt <= OpLhu) begin
            state_d = StLoad;
          end else if (data_opt == OpSw) begin
            state_d = StStore;
            wr_d    = data_in;
          end else begin
            state_d = StRmwRd;
          end
        end
      end
      StLoad: begin
        if (!dev_mem_busy) begin
          data_out_d = load_lane(op_q, addr_q[1:0], dev_mem_data_in);
          valid_d    = 1'b1;
          state_d    = StIdle;
        end
      end
      StRmwRd: begin
        if (!dev_mem_busy) begin
          wr_d    = merge(op_q, addr_q[1:0], dev_mem_data_in, wdata_q);
          state_d = StStore;
        end
      end
      StStore: begin
        if (!dev_mem_busy) begin
          valid_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle && dev_mem_busy) begin
      if (cnt_q == TimeoutLast) begin
        state_d    = StIdle;
        err_d      = 1'b1;
        data_out_d = '0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
      wr_q       <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      wr_q       <= wr_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign instr_out        = dev_mem_data_in;
  assign instr_valid      = (state_q == StIdle) && op_none && !dev_mem_busy;
  assign busy             = (state_q == StIdle) ? !op_none : 1'b1;
  assign dev_mem_addr     = ((state_q == StIdle) ? instr_addr : addr_q) & ~ADDR_WIDTH'(3);
  assign dev_mem_is_write = (state_q == StStore);
  assign dev_mem_data_out = wr_q;
  assign data_out         = data_out_q;
  assign data_valid       = valid_q;
  assign bus_err          = err_q;

endmodule
